// File: rtl/jpeg_rle_pkg.sv
// Shared types and tables for the Cb zigzag / run-length symbol stage.
// Holds the zigzag scan tables, the FSM states and the symbol record.
package jpeg_rle_pkg;

    localparam int COEF_W_DEF = 11;
    localparam int AMP_W_DEF  = 12;

    typedef enum logic [2:0] {IDLE, FIND, DC, SCAN, EOB, DONE} state_t;

    typedef struct packed {
        logic [3:0]           run;
        logic [3:0]           size;
        logic [AMP_W_DEF-1:0] amp;
        logic                 dc;
        logic                 last;
    } sym_t;

    // Zigzag index -> (row, col) of the 8x8 block
    localparam logic [2:0] ZIGZAG_ROW [64] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7,
        3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
        3'd5, 3'd6, 3'd7, 3'd7
    };

    localparam logic [2:0] ZIGZAG_COL [64] = '{
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0,
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
        3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
        3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd7
    };

endpackage

// File: rtl/cb_zigzag_rle_if.sv
// Symbol stream between the zigzag/RLE stage and the Cb Huffman encoder.
interface cb_zigzag_rle_if
    import jpeg_rle_pkg::*;
#(
    parameter int AMP_W = AMP_W_DEF
);
    logic             sym_valid;
    logic             sym_ready;
    logic [3:0]       sym_run;
    logic [3:0]       sym_size;
    logic [AMP_W-1:0] sym_amp;
    logic             sym_dc;
    logic             sym_last;

    modport master (output sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last,
                    input  sym_ready);
    modport slave  (input  sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last,
                    output sym_ready);
endinterface

// File: rtl/jpeg_size_amp.sv
// JPEG magnitude category and amplitude bits of a signed value.
module jpeg_size_amp #(
    parameter int AMP_W = 12
) (
    input  logic signed [AMP_W-1:0] val,
    output logic        [3:0]       size,
    output logic        [AMP_W-1:0] amp
);
    logic [AMP_W-1:0] mag;
    logic [AMP_W-1:0] mask;
    logic [AMP_W-1:0] vm1;

    always_comb begin
        mag  = val[AMP_W-1] ? -val : val;
        size = '0;
        for (int i = 0; i < AMP_W; i++) begin
            if (mag[i]) size = 4'(i + 1);
        end
        mask = (AMP_W'(1) << size) - AMP_W'(1);
        vm1  = val - AMP_W'(1);
        // Negative values carry the low bits of (v-1), i.e. one's complement of |v|
        amp  = val[AMP_W-1] ? (vm1 & mask) : val;
    end
endmodule

// File: rtl/cb_zigzag_rle.sv
// Cb block capture, zigzag scan, DC prediction and run/size/amplitude symbol
// generation feeding the Cb Huffman encoder.
module cb_zigzag_rle
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int AMP_W  = AMP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] Q_in [8][8],
    input  logic                     dc_clear,
    output logic                     blk_drop,
    cb_zigzag_rle_if.master          sym_bus
);
    state_t                    state_q, state_d;
    logic signed [COEF_W-1:0]  zz [64];
    logic signed [COEF_W-1:0]  pred;
    logic signed [AMP_W-1:0]   diff;
    logic        [5:0]         last_nz, lnz_d, k;
    logic        [3:0]         run;
    sym_t                      sym_q, sym_d;
    logic                      sym_vld_q, ld_sym, stall;
    logic signed [AMP_W-1:0]   sa_val;
    logic        [3:0]         sa_size;
    logic        [AMP_W-1:0]   sa_amp;

    function automatic logic signed [AMP_W-1:0] sext(input logic signed [COEF_W-1:0] v);
        return AMP_W'(v);
    endfunction

    assign in_ready = (state_q == IDLE);
    assign stall    = sym_vld_q && !sym_bus.sym_ready;
    assign sa_val   = (state_q == DC) ? diff : sext(zz[k]);

    jpeg_size_amp #(.AMP_W(AMP_W)) u_size_amp (
        .val  (sa_val),
        .size (sa_size),
        .amp  (sa_amp)
    );

    always_comb begin
        lnz_d = '0;
        for (int i = 1; i < 64; i++) begin
            if (zz[i] != '0) lnz_d = 6'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_sym  = 1'b0;
        sym_d   = sym_q;
        case (state_q)
            IDLE: if (in_valid) state_d = FIND;
            FIND: state_d = DC;
            DC: if (!stall) begin
                ld_sym  = 1'b1;
                sym_d   = '{run: 4'd0, size: sa_size, amp: AMP_W_DEF'(sa_amp), dc: 1'b1, last: 1'b0};
                state_d = (last_nz == 6'd0) ? EOB : SCAN;
            end
            SCAN: if (!stall) begin
                if (zz[k] == '0) begin
                    // ZRL is always followed by a nonzero because k never passes last_nz
                    if (run == 4'd15) begin
                        ld_sym = 1'b1;
                        sym_d  = '{run: 4'd15, size: 4'd0, amp: '0, dc: 1'b0, last: 1'b0};
                    end
                end else begin
                    ld_sym = 1'b1;
                    sym_d  = '{run: run, size: sa_size, amp: AMP_W_DEF'(sa_amp), dc: 1'b0,
                               last: (k == 6'd63)};
                end
                if (k == last_nz) state_d = (last_nz == 6'd63) ? DONE : EOB;
            end
            EOB: if (!stall) begin
                ld_sym  = 1'b1;
                sym_d   = '{run: 4'd0, size: 4'd0, amp: '0, dc: 1'b0, last: 1'b1};
                state_d = DONE;
            end
            DONE: if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            for (int i = 0; i < 64; i++) zz[i] <= Q_in[ZIGZAG_ROW[i]][ZIGZAG_COL[i]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred      <= '0;
            diff      <= '0;
            last_nz   <= '0;
            k         <= '0;
            run       <= '0;
            sym_q     <= '0;
            sym_vld_q <= 1'b0;
            blk_drop  <= 1'b0;
        end else begin
            blk_drop <= in_valid && !in_ready;
            if (state_q == IDLE && dc_clear) pred <= '0;
            if (state_q == FIND) begin
                last_nz <= lnz_d;
                diff    <= sext(zz[0]) - sext(pred);
                pred    <= zz[0];
            end
            if (state_q == DC && !stall) begin
                k   <= 6'd1;
                run <= '0;
            end
            if (state_q == SCAN && !stall) begin
                k <= k + 6'd1;
                if (zz[k] == '0 && run != 4'd15) run <= run + 4'd1;
                else                             run <= '0;
            end
            if (ld_sym) begin
                sym_q     <= sym_d;
                sym_vld_q <= 1'b1;
            end else if (!stall) begin
                sym_vld_q <= 1'b0;
            end
        end
    end

    assign sym_bus.sym_valid = sym_vld_q;
    assign sym_bus.sym_run   = sym_q.run;
    assign sym_bus.sym_size  = sym_q.size;
    assign sym_bus.sym_amp   = AMP_W'(sym_q.amp);
    assign sym_bus.sym_dc    = sym_q.dc;
    assign sym_bus.sym_last  = sym_q.last;
endmodule

// File: doc/cb_zigzag_rle.md
Name: cb_zigzag_rle

Overview:
- Consumes the 8x8 quantized Cb block produced by the Cb quantizer stage.
- Captures the block, reorders it in JPEG zigzag order and computes the DC difference against the previous block's DC.
- Emits a serial stream of JPEG run/size/amplitude symbols (DC, AC, ZRL, EOB) to the downstream Cb Huffman encoder through a valid/ready handshake.

Parameters:
- COEF_W, 11, width of each signed quantized coefficient.
- AMP_W, 12, width of the amplitude field and of the DC difference.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-high.
- in_valid  input  1  block present on Q_in (driven from quantizer out_enable).
- in_ready  output  1  block can be accepted this cycle.
- Q_in  input  COEF_W x [8][8]  quantized coefficients, two's complement, row-major [row][col].
- dc_clear  input  1  synchronous restart: DC predictor := 0.
- blk_drop  output  1  one-cycle pulse: in_valid was high while in_ready was low.
- sym_valid  output  1  symbol fields valid.
- sym_ready  input  1  downstream accepts the symbol.
- sym_run  output  4  zero-run length (0 for DC).
- sym_size  output  4  magnitude category, 0..11.
- sym_amp  output  AMP_W  JPEG amplitude bits, right-aligned, upper bits zero.
- sym_dc  output  1  current symbol is the DC symbol.
- sym_last  output  1  current symbol is the last symbol of the block.

Behaviour:
- Reset values: in_ready=1, sym_valid=0, all sym_* fields=0, blk_drop=0, DC predictor=0, state=IDLE. Reset mid-block discards the block.
- Accept: in_valid && in_ready at edge T latches all 64 coefficients. in_ready is high only in IDLE.
- blk_drop pulses on the cycle after any edge where in_valid=1 and in_ready=0. The offered block is ignored.
- State FIND (cycle T+1): priority-encode the highest zigzag index 1..63 holding a nonzero coefficient into last_nz (0 if all AC coefficients are zero).
  - Also registers diff = Q[0][0] - pred, sign-extended to AMP_W bits.
  - pred := Q[0][0].
- State DC (from T+2): sym_valid=1, sym_dc=1, run=0, size/amp derived from diff. Held until sym_ready.
- State SCAN: zigzag index k runs from 1 to last_nz, one index per cycle when no symbol is pending.
  - Zero coefficient, run<15: run++, no symbol.
  - Zero coefficient, run==15: emit ZRL (run=15, size=0, amp=0), run := 0. This is safe because last_nz guarantees a following nonzero.
  - Nonzero coefficient: emit (run, size, amp), run := 0.
  - After k == last_nz: go to EOB if last_nz < 63, else DONE.
- State EOB: emit run=0, size=0, amp=0 with sym_last=1.
  - If last_nz == 63, the coefficient-63 symbol carries sym_last=1 and no EOB is emitted.
  - If last_nz == 0, the order is DC, then EOB.
- State DONE: return to IDLE. in_ready goes high on the next cycle.
- Size/amp rule: size = bit length of |v| (0 for v=0). amp = v if v >= 0, else the low size bits of (v-1).
- Handshake: every symbol is held stable, and the FSM stalls, while sym_valid && !sym_ready.
- dc_clear applies only in IDLE or on the accept cycle. If it coincides with an accept, the new block's diff uses pred=0. dc_clear is ignored in other states.

Decomposition:
- Package jpeg_rle_pkg holds:
  - the ZIGZAG_ROW/ZIGZAG_COL [64] constant arrays;
  - the state enum (IDLE, FIND, DC, SCAN, EOB, DONE);
  - the COEF_W/AMP_W defaults;
  - the symbol struct {run, size, amp, dc, last}.
- One sub-module, jpeg_size_amp: combinational value -> {size, amp}. It is shared by the DC path and the AC path.

Test Plan:
- All-zero block, pred=0, sym_ready=1 -> two symbols: DC(0,0,0, dc=1) then EOB(0,0,0, last=1). DC symbol valid at T+2.
- Two blocks with DC=5, then DC=-3, all AC=0 -> first DC: size=3, amp=5. Second: diff=-8, size=4, amp=4'b0111.
- Zigzag index 1 = 1 and index 20 = -1, rest 0 -> DC, (0,1,1), ZRL(15,0), (2,1,0), EOB.
- Coefficient at index 63 = 2047 and 17 zeros before it -> ... (15,0,0), (1,11,2047) with sym_last=1 and no EOB.
- sym_ready low for 5 cycles mid-block -> symbol held stable. in_valid during the block -> blk_drop pulse, in_ready=0.
- Assert rst mid-SCAN, then send a block with DC=4 -> outputs reset immediately, pred=0, DC diff=4 (size 3). dc_clear with DC=7 -> diff=7.
